encoding_decoder_pipe: RTL

//  Receive-side counterpart of Encoding_module. Accepts a 7-bit encoded word (one-hot or Gray,
//  per USE_GRAY) over a valid/ready stream and recovers the 3-bit value. Flags illegal code words
//  and keeps a saturating error count. Two-stage registered pipeline at the receiver boundary.

---
 rtl/encoding_decoder_pipe_pkg.sv | 30 +++
 rtl/encoding_decoder_pipe_code_check_decode.sv | 32 +++
 rtl/encoding_decoder_pipe.sv | 69 ++++++
 3 files changed

// File: rtl/encoding_decoder_pipe_pkg.sv
// Shared code-word widths, pipeline stage structs and the Gray-to-binary helper
// used by the receive-side decoder and its sub-modules.
package encoding_decoder_pipe_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 3;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  vld;
    code_t code;
  } s1_t;

  typedef struct packed {
    logic  vld;
    logic  err;
    data_t data;
  } s2_t;

  function automatic data_t gray_to_bin(input data_t g);
    data_t b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/encoding_decoder_pipe_code_check_decode.sv
// Combinational code-word check and decode, one-hot or Gray selected by USE_GRAY.
// Latency: none (pure logic). Backpressure: not applicable.
// Illegal words decode to value 0 so nothing downstream ever sees a partial decode.
module code_check_decode
  import encoding_decoder_pipe_pkg::*;
#(
  parameter bit USE_GRAY = 1'b0
) (
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] value,
  output logic              illegal
);

  generate
    if (USE_GRAY) begin : g_gray
      always_comb begin
        illegal = |code[6:3];
        value   = illegal ? '0 : gray_to_bin(code[2:0]);
      end
    end else begin : g_onehot
      always_comb begin
        illegal = ($countones(code) > 1);
        value   = '0;
        for (int i = 0; i < CODE_W; i++) begin
          if (code[i]) value = data_t'(i + 1);
        end
        if (illegal) value = '0;
      end
    end
  endgenerate

endmodule

// File: rtl/encoding_decoder_pipe.sv
// Receive-side decoder: 7-bit one-hot/Gray word in, 3-bit value plus illegal flag out.
// Latency: 2 clk from input handshake to output handshake at full rate, 1 word/clk.
// Backpressure: both stages hold while out_valid && !out_ready; in_ready = adv, no skid buffer.
module encoding_decoder_pipe
  import encoding_decoder_pipe_pkg::*;
#(
  parameter bit USE_GRAY = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  s1_t   s1_q;
  s2_t   s2_q;
  data_t dec_value;
  logic  dec_illegal;
  logic  adv;
  logic  out_hs;

  assign adv      = !s2_q.vld || out_ready;
  assign in_ready = adv;
  assign out_hs   = s2_q.vld && out_ready;

  code_check_decode #(.USE_GRAY(USE_GRAY)) u_decode (
    .code    (s1_q.code),
    .value   (dec_value),
    .illegal (dec_illegal)
  );

  // Invalid slots carry all-zero payload so no X can leak from an idle in_code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (adv) begin
      s1_q.vld  <= in_valid;
      s1_q.code <= in_valid ? in_code : '0;
      s2_q.vld  <= s1_q.vld;
      s2_q.err  <= s1_q.vld && dec_illegal;
      s2_q.data <= s1_q.vld ? dec_value : '0;
    end
  end

  // Clear takes priority; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_hs && s2_q.err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign out_valid = s2_q.vld;
  assign out_data  = s2_q.data;
  assign out_err   = s2_q.err;

endmodule
